// File: rtl/cache_pkg.sv
// Cache line layout and refill FSM states, shared between the cache and its refill controller.
// Line layout (MSB first): valid[152], tag[151:128], w3[127:96], w2[95:64], w1[63:32], w0[31:0].
package cache_pkg;

  localparam int unsigned LINE_TAG_W  = 24;
  localparam int unsigned LINE_WORD_W = 32;
  localparam int unsigned LINE_WORDS  = 4;

  typedef struct packed {
    logic                                    valid;
    logic [LINE_TAG_W-1:0]                   tag;
    logic [LINE_WORDS-1:0][LINE_WORD_W-1:0]  words;
  } cache_line_t;

  // HOLD is only occupied under reset and is left on the first clock after release
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    IDLE = 2'd1,
    REQ  = 2'd2,
    DONE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// Miss/memory/fill signal bundle for cache_refill_ctrl; master is the controller side,
// slave is the cache plus backing-RAM side.
interface cache_refill_ctrl_if #(
  parameter int unsigned RAM_ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned CACHE_DATA_WIDTH    = 153,
  parameter int unsigned CACHE_ADDRESS_WIDTH = 4
);

  logic                           miss_valid;
  logic [RAM_ADDRESS_WIDTH-1:0]   miss_addr;
  logic                           miss_ready;
  logic                           mem_req;
  logic [RAM_ADDRESS_WIDTH-1:0]   mem_addr;
  logic                           mem_ack;
  logic [DATA_WIDTH-1:0]          mem_rdata;
  logic                           fill_valid;
  logic [CACHE_ADDRESS_WIDTH-1:0] fill_set;
  logic [CACHE_DATA_WIDTH-1:0]    fill_line;
  logic                           crit_valid;
  logic [DATA_WIDTH-1:0]          crit_data;
  logic                           busy;

  modport master (
    input  miss_valid, miss_addr, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, fill_valid, fill_set, fill_line,
           crit_valid, crit_data, busy
  );

  modport slave (
    output miss_valid, miss_addr, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, fill_valid, fill_set, fill_line,
           crit_valid, crit_data, busy
  );

endinterface

// File: rtl/cache_refill_ctrl.sv
// Four-beat cache line refill controller: accepts a read miss, fetches the line word by word
// and emits a one-cycle fill. Define CRITICAL_WORD_FIRST_EN to fetch the missed word first.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned RAM_ADDRESS_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH          = 32,
  parameter int unsigned CACHE_DATA_WIDTH    = 153,
  parameter int unsigned CACHE_ADDRESS_WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_refill_ctrl_if.master bus
);

  localparam int unsigned TAG_W = RAM_ADDRESS_WIDTH - CACHE_ADDRESS_WIDTH - 4;

  refill_state_e                     state_q, state_d;
  logic [TAG_W-1:0]                  tag_q, tag_d;
  logic [CACHE_ADDRESS_WIDTH-1:0]    set_q, set_d;
  logic [2:0]                        cnt_q, cnt_d;
  logic [3:0][DATA_WIDTH-1:0]        words_q, words_d;
  logic [1:0]                        idx_c, idx_d;

  logic                              miss_ready_q, miss_ready_d;
  logic                              busy_q, busy_d;
  logic                              mem_req_q, mem_req_d;
  logic [RAM_ADDRESS_WIDTH-1:0]      mem_addr_q, mem_addr_d;
  logic                              fill_valid_q, fill_valid_d;
  logic [CACHE_ADDRESS_WIDTH-1:0]    fill_set_q, fill_set_d;
  logic [CACHE_DATA_WIDTH-1:0]       fill_line_q;
  cache_line_t                       fill_line_d;

  // Byte-offset bits never select anything; word-offset bits only matter for critical-word-first
  logic unused_addr_c;
  assign unused_addr_c = ^bus.miss_addr[3:0];

`ifdef CRITICAL_WORD_FIRST_EN
  logic [1:0]            off_q, off_d;
  logic                  crit_valid_q, crit_valid_d;
  logic [DATA_WIDTH-1:0] crit_data_q, crit_data_d;
  assign idx_c = 2'(off_q + cnt_q[1:0]);
`else
  assign idx_c = cnt_q[1:0];
`endif

  // Next state, line capture, and next values of every registered output
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    set_d   = set_q;
    cnt_d   = cnt_q;
    words_d = words_q;
`ifdef CRITICAL_WORD_FIRST_EN
    off_d   = off_q;
`endif

    case (state_q)
      HOLD: state_d = IDLE;
      IDLE: begin
        if (bus.miss_valid) begin
          state_d = REQ;
          tag_d   = bus.miss_addr[RAM_ADDRESS_WIDTH-1 -: TAG_W];
          set_d   = bus.miss_addr[4 +: CACHE_ADDRESS_WIDTH];
          cnt_d   = 3'd0;
`ifdef CRITICAL_WORD_FIRST_EN
          off_d   = bus.miss_addr[3:2];
`endif
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          words_d[idx_c] = bus.mem_rdata;
          cnt_d          = cnt_q + 3'd1;
          if (cnt_q == 3'd3) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef CRITICAL_WORD_FIRST_EN
    idx_d        = 2'(off_d + cnt_d[1:0]);
    crit_valid_d = (state_q == REQ) && bus.mem_ack && (cnt_q == 3'd0);
    crit_data_d  = crit_valid_d ? bus.mem_rdata : crit_data_q;
`else
    idx_d        = cnt_d[1:0];
`endif

    miss_ready_d = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    mem_req_d    = (state_d == REQ);
    mem_addr_d   = '0;
    if (mem_req_d) mem_addr_d = {tag_d, set_d, idx_d, 2'b00};

    fill_valid_d = (state_d == DONE);
    fill_set_d   = '0;
    fill_line_d  = '0;
    if (fill_valid_d) begin
      fill_set_d        = set_d;
      fill_line_d.valid = 1'b1;
      fill_line_d.tag   = tag_d;
      fill_line_d.words = words_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HOLD;
      tag_q        <= '0;
      set_q        <= '0;
      cnt_q        <= '0;
      words_q      <= '0;
      miss_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_set_q   <= '0;
      fill_line_q  <= '0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      set_q        <= set_d;
      cnt_q        <= cnt_d;
      words_q      <= words_d;
      miss_ready_q <= miss_ready_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_set_q   <= fill_set_d;
      fill_line_q  <= fill_line_d;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q        <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      off_q        <= off_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

  assign bus.miss_ready = miss_ready_q;
  assign bus.busy       = busy_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.fill_valid = fill_valid_q;
  assign bus.fill_set   = fill_set_q;
  assign bus.fill_line  = fill_line_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl; the RAM model returns each word's own address as data.
module tb_cache_refill_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete miss-to-fill transaction, optionally stalling one beat for stall_n cycles
  task automatic refill(input logic [31:0] addr, input logic [31:0] ea [4], input int stall_beat,
                        input int stall_n, input logic [3:0] eset, input logic [152:0] eline,
                        input logic keep_valid);
    bus.miss_valid = 1'b1;
    bus.miss_addr  = addr;
    chk("idle_ready", 160'({bus.miss_ready, bus.busy}), 160'(2'b10));
    tick();
    bus.miss_valid = keep_valid;
    chk("accept", 160'({bus.busy, bus.miss_ready, bus.mem_req}), 160'(3'b101));
    for (int b = 0; b < 4; b++) begin
      if (b == stall_beat) begin
        bus.mem_ack = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_addr", 160'({bus.mem_req, bus.mem_addr}), 160'({1'b1, ea[b]}));
          tick();
        end
      end
      chk("req_addr", 160'({bus.fill_valid, bus.miss_ready, bus.mem_req, bus.mem_addr}),
          160'({1'b0, 1'b0, 1'b1, ea[b]}));
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bus.mem_addr;
      tick();
`ifdef CRITICAL_WORD_FIRST_EN
      if (b == 0) chk("crit", 160'({bus.crit_valid, bus.crit_data}), 160'({1'b1, ea[0]}));
`else
      if (b == 0) chk("crit", 160'({bus.crit_valid, bus.crit_data}), 160'(0));
`endif
      if (b == 1) chk("crit_drop", 160'(bus.crit_valid), 160'(1'b0));
    end
    bus.mem_ack = 1'b0;
    chk("fill", 160'({bus.fill_valid, bus.fill_set, bus.mem_req, bus.miss_ready}),
        160'({1'b1, eset, 1'b0, 1'b0}));
    chk("fill_line", 160'(bus.fill_line), 160'(eline));
    tick();
    chk("post_fill", {bus.fill_valid, bus.fill_set, bus.fill_line, bus.miss_ready, bus.busy},
        {1'b0, 4'h0, 153'h0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [31:0]  a34 [4];
    logic [31:0]  a38 [4];
    logic [31:0]  a78 [4];
    logic [152:0] line1;
    logic [152:0] line2;

`ifdef CRITICAL_WORD_FIRST_EN
    a34 = '{32'h0001_0034, 32'h0001_0038, 32'h0001_003C, 32'h0001_0030};
    a38 = '{32'h0001_0038, 32'h0001_003C, 32'h0001_0030, 32'h0001_0034};
    a78 = '{32'h1234_5678, 32'h1234_567C, 32'h1234_5670, 32'h1234_5674};
`else
    a34 = '{32'h0001_0030, 32'h0001_0034, 32'h0001_0038, 32'h0001_003C};
    a38 = '{32'h0001_0030, 32'h0001_0034, 32'h0001_0038, 32'h0001_003C};
    a78 = '{32'h1234_5670, 32'h1234_5674, 32'h1234_5678, 32'h1234_567C};
`endif
    line1 = {1'b1, 24'h000100, 32'h0001_003C, 32'h0001_0038, 32'h0001_0034, 32'h0001_0030};
    line2 = {1'b1, 24'h123456, 32'h1234_567C, 32'h1234_5678, 32'h1234_5674, 32'h1234_5670};

    rst_n          = 1'b0;
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;
    repeat (2) tick();

    chk("rst_outs", 160'({bus.miss_ready, bus.mem_req, bus.mem_addr, bus.fill_valid, bus.fill_set,
                          bus.crit_valid, bus.crit_data, bus.busy}), 160'(0));
    chk("rst_line", 160'(bus.fill_line), 160'(0));

    rst_n = 1'b1;
    tick();
    chk("hold_exit", 160'({bus.miss_ready, bus.busy, bus.mem_req}), 160'(3'b100));

    // Acks while idle must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spurious_ack", 160'({bus.miss_ready, bus.busy, bus.mem_req, bus.fill_valid}),
          160'(4'b1000));
    end
    bus.mem_ack = 1'b0;

    refill(32'h0001_0034, a34, -1, 0, 4'd3, line1, 1'b0);
    refill(32'h1234_5678, a78, 1, 3, 4'd7, line2, 1'b0);

    // Miss held high: second one goes in the cycle right after the fill
    refill(32'h0001_0038, a38, -1, 0, 4'd3, line1, 1'b1);
    refill(32'h1234_5678, a78, -1, 0, 4'd7, line2, 1'b0);

    // Reset after the second beat lands
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0001_0034;
    tick();
    bus.miss_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = bus.mem_addr;
      tick();
    end
    chk("mid_busy", 160'({bus.busy, bus.mem_req}), 160'(2'b11));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 160'({bus.miss_ready, bus.mem_req, bus.mem_addr, bus.fill_valid,
                              bus.fill_set, bus.crit_valid, bus.crit_data, bus.busy}), 160'(0));
    chk("mid_rst_line", 160'(bus.fill_line), 160'(0));
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_no_fill", 160'({bus.fill_valid, bus.mem_req}), 160'(0));
    end
    rst_n       = 1'b1;
    bus.mem_ack = 1'b0;
    tick();
    chk("rst_recover", 160'({bus.miss_ready, bus.busy, bus.fill_valid}), 160'(3'b100));
    tick();
    chk("rst_no_late_fill", 160'(bus.fill_valid), 160'(1'b0));
    refill(32'h1234_5678, a78, -1, 0, 4'd7, line2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
